// File: rtl/ila_sample_unpacker_pkg.sv
// ----------------------------------------------------------------------------
// ila_sample_unpacker_pkg
//   Shared definitions for the ILA sample unpacker: controller state encoding
//   and the ceiling-division helper used to size the beat count per sample.
// ----------------------------------------------------------------------------
package ila_sample_unpacker_pkg;

    typedef enum logic [1:0] {
        ILA_UNPK_IDLE = 2'd0,
        ILA_UNPK_RUN  = 2'd1,
        ILA_UNPK_DONE = 2'd2
    } ila_unpk_state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/ila_unpack_slot.sv
// ----------------------------------------------------------------------------
// ila_unpack_slot
//   One-deep output register with ready pass-through. A new word may load in
//   the same cycle the held word is taken, giving full throughput.
// Ports:
//   clk_i       in   system clock
//   arst_i      in   async reset, active-low
//   clr_i       in   sync clear (drops any held word)
//   in_valid_i  in   load request (only honoured while in_ready_o)
//   in_data_i   in   word to load
//   in_ready_o  out  slot empty or being emptied this cycle
//   out_valid_o out  slot holds a word
//   out_data_o  out  held word (zero after reset/clear)
//   out_ready_i in   consumer accept
// ----------------------------------------------------------------------------
module ila_unpack_slot #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         arst_i,
    input  logic         clr_i,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         in_ready_o,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o,
    input  logic         out_ready_i
);

    logic         r_valid;
    logic [W-1:0] r_data;
    logic         w_load;

    assign in_ready_o  = ~r_valid | out_ready_i;
    assign w_load      = in_valid_i & in_ready_o;
    assign out_valid_o = r_valid;
    assign out_data_o  = r_data;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from the same pre-edge values.
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            r_valid <= 1'b0;
        end else if (clr_i) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
        end else if (out_ready_i) begin
            r_valid <= 1'b0;
        end
    end

    // NOTE: the data register is reset too, because the sample outputs must
    // read zero after reset rather than stale or X contents.
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            r_data <= '0;
        end else if (clr_i) begin
            r_data <= '0;
        end else if (w_load) begin
            r_data <= in_data_i;
        end
    end

endmodule

// File: rtl/ila_sample_unpacker.sv
// ----------------------------------------------------------------------------
// ila_sample_unpacker
//   Receiving end of the ILA DMA sample stream. Collects NWORDS beats (least
//   significant first) into one sample, splits off the optional clock-counter
//   timestamp, computes the delta to the previous timestamp and counts
//   delivered samples against a total programmed at start.
// Ports:
//   clk_i          in   system clock
//   arst_i         in   async reset, active-low
//   rst_i          in   sync soft reset, active-high
//   start_i        in   arm/restart capture of n_samples_i samples
//   n_samples_i    in   total samples expected (sampled on start_i)
//   s_tdata_i      in   stream beat
//   s_tvalid_i     in   beat valid
//   s_tready_o     out  beat accept
//   sample_o       out  reassembled user signal
//   timestamp_o    out  sample timestamp (0 without clock counter)
//   delta_o        out  timestamp minus previous timestamp (0 on first)
//   sample_valid_o out  output sample valid
//   sample_ready_i in   consumer accept
//   count_o        out  samples delivered since start
//   busy_o         out  capture running
//   done_o         out  capture complete
//   pad_err_o      out  sticky: nonzero pad bits seen in a last beat
// ----------------------------------------------------------------------------
module ila_sample_unpacker
    import ila_sample_unpacker_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int SIGNAL_W      = 40,
    parameter int CLK_COUNTER   = 0,
    parameter int CLK_COUNTER_W = 16,
    parameter int BUFFER_W      = 10
) (
    input  logic                     clk_i,
    input  logic                     arst_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [BUFFER_W-1:0]      n_samples_i,
    input  logic [DATA_W-1:0]        s_tdata_i,
    input  logic                     s_tvalid_i,
    output logic                     s_tready_o,
    output logic [SIGNAL_W-1:0]      sample_o,
    output logic [CLK_COUNTER_W-1:0] timestamp_o,
    output logic [CLK_COUNTER_W-1:0] delta_o,
    output logic                     sample_valid_o,
    input  logic                     sample_ready_i,
    output logic [BUFFER_W-1:0]      count_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     pad_err_o
);

    localparam int TS_OFS     = (CLK_COUNTER != 0) ? CLK_COUNTER_W : 0;
    localparam int I_SIGNAL_W = SIGNAL_W + TS_OFS;
    localparam int NWORDS     = ceil_div(I_SIGNAL_W, DATA_W);
    localparam int IDX_W      = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int ASM_W      = NWORDS * DATA_W;
    localparam int SLOT_W     = SIGNAL_W + 2 * CLK_COUNTER_W;
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NWORDS - 1);
    // Every assembled bit at or above I_SIGNAL_W is padding.
    localparam logic [ASM_W-1:0] ASM_PAD_MASK = {ASM_W{1'b1}} << I_SIGNAL_W;

    ila_unpk_state_t r_state, w_state_nxt;

    logic [IDX_W-1:0]         r_idx;
    logic [BUFFER_W-1:0]      r_count;
    logic [BUFFER_W-1:0]      r_total;
    logic                     r_pad_err;
    logic                     r_first;
    logic [CLK_COUNTER_W-1:0] r_prev_ts;

    logic                     w_busy, w_done;
    logic                     w_clr;
    logic                     w_beat, w_last_word, w_load;
    logic                     w_slot_in_ready, w_slot_valid;
    logic                     w_out_hs, w_final_hs, w_all_claimed;
    logic [ASM_W-1:0]         w_full;
    logic                     w_pad;
    logic [SIGNAL_W-1:0]      w_sig;
    logic [CLK_COUNTER_W-1:0] w_ts, w_delta;
    logic [SLOT_W-1:0]        w_slot_data;

    // Soft reset and start both throw away partial assembly and the slot.
    assign w_clr = rst_i | start_i;

    // ---------------- handshakes ----------------
    assign w_beat      = s_tvalid_i & s_tready_o;
    assign w_last_word = (r_idx == LAST_IDX);
    // A last beat landing together with start_i belongs to the old capture.
    assign w_load      = w_beat & w_last_word & ~start_i;
    assign w_out_hs    = w_slot_valid & sample_ready_i;
    assign w_final_hs  = w_out_hs &
                         (({1'b0, r_count} + (BUFFER_W + 1)'(1)) == {1'b0, r_total});
    // Stop pulling beats once the held sample is the last one of the total.
    assign w_all_claimed = ({1'b0, r_count} + (BUFFER_W + 1)'(w_slot_valid))
                           == {1'b0, r_total};
    assign s_tready_o  = w_busy & w_slot_in_ready & ~w_all_claimed;

    // ---------------- assembly ----------------
    generate
        if (NWORDS > 1) begin : g_multi
            logic [(NWORDS-1)*DATA_W-1:0] r_asm;

            always_ff @(posedge clk_i or negedge arst_i) begin
                if (!arst_i) begin
                    r_asm <= '0;
                end else if (w_clr) begin
                    r_asm <= '0;
                end else if (w_beat && !w_last_word) begin
                    r_asm[DATA_W*r_idx +: DATA_W] <= s_tdata_i;
                end
            end

            // The last beat goes straight into the slot without a stop here.
            assign w_full = {s_tdata_i, r_asm};
        end else begin : g_single
            assign w_full = s_tdata_i;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            r_idx <= '0;
        end else if (w_clr) begin
            r_idx <= '0;
        end else if (w_beat) begin
            r_idx <= w_last_word ? '0 : r_idx + IDX_W'(1);
        end
    end

    assign w_pad = |(w_full & ASM_PAD_MASK);
    assign w_sig = w_full[TS_OFS +: SIGNAL_W];

    generate
        if (CLK_COUNTER != 0) begin : g_ts
            assign w_ts = w_full[CLK_COUNTER_W-1:0];
        end else begin : g_no_ts
            assign w_ts = '0;
        end
    endgenerate

    // ---------------- timestamp delta ----------------
    assign w_delta = r_first ? '0 : w_ts - r_prev_ts;

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            r_first   <= 1'b1;
            r_prev_ts <= '0;
        end else if (w_clr) begin
            r_first   <= 1'b1;
            r_prev_ts <= '0;
        end else if (w_load) begin
            r_first   <= 1'b0;
            r_prev_ts <= w_ts;
        end
    end

    // ---------------- counters and flags ----------------
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            r_count   <= '0;
            r_total   <= '0;
            r_pad_err <= 1'b0;
        end else if (rst_i) begin
            r_count   <= '0;
            r_total   <= '0;
            r_pad_err <= 1'b0;
        end else if (start_i) begin
            r_count   <= '0;
            r_total   <= n_samples_i;
            r_pad_err <= 1'b0;
        end else begin
            if (w_out_hs) begin
                r_count <= r_count + BUFFER_W'(1);
            end
            if (w_load && w_pad) begin
                r_pad_err <= 1'b1;
            end
        end
    end

    // ---------------- output slot ----------------
    ila_unpack_slot #(
        .W (SLOT_W)
    ) u_slot (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .clr_i       (w_clr),
        .in_valid_i  (w_load),
        .in_data_i   ({w_sig, w_ts, w_delta}),
        .in_ready_o  (w_slot_in_ready),
        .out_valid_o (w_slot_valid),
        .out_data_o  (w_slot_data),
        .out_ready_i (sample_ready_i)
    );

    assign {sample_o, timestamp_o, delta_o} = w_slot_data;
    assign sample_valid_o = w_slot_valid;
    assign count_o        = r_count;
    assign pad_err_o      = r_pad_err;
    assign busy_o         = w_busy;
    assign done_o         = w_done;

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            r_state <= ILA_UNPK_IDLE;
        end else if (rst_i) begin
            r_state <= ILA_UNPK_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        if (start_i) begin
            w_state_nxt = (n_samples_i == '0) ? ILA_UNPK_DONE : ILA_UNPK_RUN;
        end else if (r_state == ILA_UNPK_RUN && w_final_hs) begin
            w_state_nxt = ILA_UNPK_DONE;
        end
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            ILA_UNPK_RUN:  w_busy = 1'b1;
            ILA_UNPK_DONE: w_done = 1'b1;
            default:       ;
        endcase
    end

endmodule
